z80_bus_sync: RTL

Synchronizes the Z8S180 bus strobes into the `hwclk` domain, classifies each bus cycle, and emits single-`hwclk` start/end pulses together with the latched address and write data. It sits between the CPU pins and the FPGA-resident bus consumers: the boot ROM, the SRAM chip-select logic, and memory/I/O-mapped registers such as the LED latch. It also drives `/WAIT` to stretch I/O cycles by a programmable number of `hwclk` cycles.

---
 rtl/z80_bus_sync.sv | 97 +++++++++
 1 files changed

// File: rtl/z80_bus_sync.sv
// z80_bus_sync: synchronizes Z8S180 strobes into hwclk, classifies bus cycles, inserts I/O wait states
// Ports: hwclk/reset_n (async active-low) clock and reset; a, d_in raw CPU address/data;
//   mreq_n..rfsh_n raw CPU strobes; wait_n to CPU /WAIT; cyc_start/cyc_end one-clock pulses;
//   cyc_type, cyc_addr latched at start; wr_data latched at end of writes; busy while not IDLE.
module z80_bus_sync #(
  parameter int ADDR_WIDTH   = 20,
  parameter int IO_WAIT_CLKS = 4
) (
  input  logic                  hwclk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [7:0]            d_in,
  input  logic                  mreq_n,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  m1_n,
  input  logic                  rfsh_n,
  output logic                  wait_n,
  output logic                  cyc_start,
  output logic                  cyc_end,
  output logic [2:0]            cyc_type,
  output logic [ADDR_WIDTH-1:0] cyc_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);
  localparam int CW = (IO_WAIT_CLKS > 0) ? $clog2(IO_WAIT_CLKS + 1) : 1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} state_t;
  state_t          state_q, state_d;
  logic [5:0]      s1, s2;
  logic            s_mreq, s_iorq, s_rd, s_wr, s_m1, s_rfsh;
  logic [2:0]      typ;
  logic            q, io_wait, start_d, end_d, wait_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [7:0]      shadow;
  // Strobes inverted to active-high before the 2-flop synchronizer, so reset 0 is the inactive level
  always_ff @(posedge hwclk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~{mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n};
      s2 <= s1;
    end
  assign {s_mreq, s_iorq, s_rd, s_wr, s_m1, s_rfsh} = s2;
  always_comb begin
    typ = (s_iorq & s_m1)                     ? 3'd7 :
          (s_mreq & s_rfsh & ~s_rd & ~s_wr)   ? 3'd6 :
          (s_iorq & s_wr)                     ? 3'd5 :
          (s_iorq & s_rd)                     ? 3'd4 :
          (s_mreq & s_rd & s_m1)              ? 3'd3 :
          (s_mreq & s_wr)                     ? 3'd2 :
          (s_mreq & s_rd)                     ? 3'd1 : 3'd0;
    q       = typ != 3'd0;
    io_wait = (IO_WAIT_CLKS > 0) && (typ == 3'd4 || typ == 3'd5 || typ == 3'd7);
  end
  always_ff @(posedge hwclk or negedge reset_n)
    if (!reset_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  // Any non-IDLE state other than a still-counting WAIT behaves as ACTIVE
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (q ? (io_wait ? ST_WAIT : ST_ACTIVE) : ST_IDLE) :
              !q                                  ? ST_IDLE :
              (state_q == ST_WAIT && cnt != CW'(1)) ? ST_WAIT : ST_ACTIVE;
  end
  // Next values of the registered outputs; wait_n is low exactly while the next state is WAIT
  always_comb begin
    start_d = (state_q == ST_IDLE) && q;
    end_d   = (state_q != ST_IDLE) && !q;
    wait_d  = state_d != ST_WAIT;
    cnt_d   = start_d ? CW'(IO_WAIT_CLKS) :
              (state_q == ST_WAIT && cnt != '0) ? cnt - CW'(1) : cnt;
  end
  always_ff @(posedge hwclk or negedge reset_n)
    if (!reset_n) begin
      cnt       <= '0;
      wait_n    <= 1'b1;
      cyc_start <= 1'b0;
      cyc_end   <= 1'b0;
      cyc_type  <= 3'd0;
      cyc_addr  <= '0;
      shadow    <= 8'd0;
      wr_data   <= 8'd0;
    end else begin
      cnt       <= cnt_d;
      wait_n    <= wait_d;
      cyc_start <= start_d;
      cyc_end   <= end_d;
      if (start_d) begin
        cyc_type <= typ;
        cyc_addr <= a;
      end
      if (state_q != ST_IDLE && s_wr) shadow <= d_in;
      if (end_d && (cyc_type == 3'd2 || cyc_type == 3'd5)) wr_data <= shadow;
    end
  assign busy = state_q != ST_IDLE;
endmodule
